// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared console state type, ASCII codes and default screen geometry
package vgachargen_pkg;

    typedef enum logic {IDLE, CLEAR} console_state_t;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/vgachargen_console_if.sv
// vgachargen_console_if: byte-stream intake, char-map write port and cursor/status of the console
interface vgachargen_console_if
    import vgachargen_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 10
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [7:0]        data_i;
    logic              valid_i;
    logic              ready_o;
    logic [ADDR_W-1:0] char_map_addr_o;
    logic              char_map_ce_o;
    logic              char_map_we_o;
    logic [3:0]        char_map_be_o;
    logic [31:0]       char_map_wdata_o;
    logic [CW-1:0]     col_o;
    logic [RW-1:0]     row_o;
    logic              busy_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, char_map_addr_o, char_map_ce_o, char_map_we_o,
        input  char_map_be_o, char_map_wdata_o, col_o, row_o, busy_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, char_map_addr_o, char_map_ce_o, char_map_we_o,
        output char_map_be_o, char_map_wdata_o, col_o, row_o, busy_o
    );

endinterface

// File: rtl/vgachargen_cursor.sv
// vgachargen_cursor: column/row text cursor with advance, newline, carriage return, backspace and home
module vgachargen_cursor #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          inc,
    input  logic          newline,
    input  logic          cr,
    input  logic          bs,
    input  logic          home,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row
);

    logic          col_last;
    logic [RW-1:0] row_next;

    assign col_last = col == CW'(COLS - 1);
    assign row_next = row == RW'(ROWS - 1) ? '0 : row + 1'b1;

    // Apply this cycle's command; home overrides everything, the screen wraps instead of scrolling
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            col <= '0;
            row <= '0;
        end else if (home) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row_next;
        end else if (newline) begin
            col <= '0;
            row <= row_next;
        end else if (cr) begin
            col <= '0;
        end else if (bs && col != '0) begin
            col <= col - 1'b1;
        end
    end

endmodule

// File: rtl/vgachargen_console.sv
// vgachargen_console: byte-stream text console writing characters into the vgachargen char map
// Optional form-feed screen clear is built when VGACHARGEN_CONSOLE_CLEAR_EN is defined.
module vgachargen_console
    import vgachargen_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 10
) (
    input logic                clk_i,
    input logic                arstn_i,
    vgachargen_console_if.slave con
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int IW = ADDR_W + 2;
    localparam int NW = COLS * ROWS / 4;

    logic          take;
    logic          inc;
    logic          sweep;
    logic          ff;
    logic          home;
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign take = con.valid_i && con.ready_o;
    assign inc  = take && con.data_i >= ASCII_SPACE && con.data_i <= 8'h7E;
    assign idx  = IW'(row) * IW'(COLS) + IW'(col);

    assign con.col_o = col;
    assign con.row_o = row;

    vgachargen_cursor #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) u_cursor (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .inc     (inc),
        .newline (take && con.data_i == ASCII_LF),
        .cr      (take && con.data_i == ASCII_CR),
        .bs      (take && con.data_i == ASCII_BS),
        .home    (home),
        .col     (col),
        .row     (row)
    );

`ifdef VGACHARGEN_CONSOLE_CLEAR_EN
    console_state_t state;
    logic           clear_done;

    assign ff         = take && con.data_i == ASCII_FF;
    assign clear_done = state == CLEAR && con.char_map_addr_o == ADDR_W'(NW - 1);
    assign sweep      = ff || (state == CLEAR && !clear_done);
    assign home       = clear_done;

    // Enter the clear sweep on form feed and leave it once the last word has been written
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            con.busy_o <= 1'b0;
        end else if (ff) begin
            state      <= CLEAR;
            con.busy_o <= 1'b1;
        end else if (clear_done) begin
            state      <= IDLE;
            con.busy_o <= 1'b0;
        end
    end
`else
    assign ff         = 1'b0;
    assign sweep      = 1'b0;
    assign home       = 1'b0;
    assign con.busy_o = 1'b0;
`endif

    // Register the char-map write: one byte lane for a printable char, a full space word while clearing
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            con.ready_o          <= 1'b0;
            con.char_map_ce_o    <= 1'b0;
            con.char_map_we_o    <= 1'b0;
            con.char_map_be_o    <= 4'h0;
            con.char_map_addr_o  <= '0;
            con.char_map_wdata_o <= '0;
        end else begin
            con.ready_o       <= !sweep;
            con.char_map_ce_o <= inc || sweep;
            con.char_map_we_o <= inc || sweep;
            con.char_map_be_o <= sweep ? 4'hF : inc ? 4'b0001 << idx[1:0] : 4'h0;
            if (sweep) begin
                con.char_map_addr_o  <= ff ? '0 : con.char_map_addr_o + 1'b1;
                con.char_map_wdata_o <= {4{ASCII_SPACE}};
            end else if (inc) begin
                con.char_map_addr_o  <= idx[IW-1:2];
                con.char_map_wdata_o <= {4{con.data_i}};
            end
        end
    end

endmodule

// File: tb/tb_vgachargen_console.sv
// tb_vgachargen_console: directed and randomized checks of the console against a linear-index screen model
module tb_vgachargen_console;
    import vgachargen_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int NCH  = COLS * ROWS;
    localparam int NW   = NCH / 4;

    logic clk   = 1'b0;
    logic arstn = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    logic        exp_ce;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic        exp_ready;
    logic        exp_busy;

    vgachargen_console_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) con ();

    vgachargen_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .con     (con)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ce"}, 32'(con.char_map_ce_o), 32'(exp_ce));
        chk({tag, ".we"}, 32'(con.char_map_we_o), 32'(exp_ce));
        chk({tag, ".be"}, 32'(con.char_map_be_o), exp_ce ? 32'(exp_be) : 32'h0);
        if (exp_ce) begin
            chk({tag, ".addr"}, 32'(con.char_map_addr_o), exp_addr);
            chk({tag, ".wdata"}, con.char_map_wdata_o, exp_wd);
        end
        chk({tag, ".col"}, 32'(con.col_o), 32'(cur % COLS));
        chk({tag, ".row"}, 32'(con.row_o), 32'(cur / COLS));
        chk({tag, ".ready"}, 32'(con.ready_o), 32'(exp_ready));
        chk({tag, ".busy"}, 32'(con.busy_o), 32'(exp_busy));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ready"}, 32'(con.ready_o), 32'h0);
        chk({tag, ".ce"}, 32'(con.char_map_ce_o), 32'h0);
        chk({tag, ".we"}, 32'(con.char_map_we_o), 32'h0);
        chk({tag, ".be"}, 32'(con.char_map_be_o), 32'h0);
        chk({tag, ".addr"}, 32'(con.char_map_addr_o), 32'h0);
        chk({tag, ".wdata"}, con.char_map_wdata_o, 32'h0);
        chk({tag, ".col"}, 32'(con.col_o), 32'h0);
        chk({tag, ".row"}, 32'(con.row_o), 32'h0);
        chk({tag, ".busy"}, 32'(con.busy_o), 32'h0);
    endtask

    // Screen model: the cursor is a single linear index into a COLS*ROWS screen
    task automatic model(input logic [7:0] d);
        exp_ce    = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        if (d >= 8'h20 && d <= 8'h7E) begin
            exp_ce   = 1'b1;
            exp_addr = 32'(cur / 4);
            exp_be   = 4'(1 << (cur % 4));
            exp_wd   = {4{d}};
            cur      = (cur + 1) % NCH;
        end else if (d == 8'h0D) begin
            cur = cur - cur % COLS;
        end else if (d == 8'h0A) begin
            cur = ((cur / COLS + 1) % ROWS) * COLS;
        end else if (d == 8'h08 && cur % COLS > 0) begin
            cur = cur - 1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        con.valid_i = 1'b1;
        con.data_i  = d;
        model(d);
        @(negedge clk);
        chk_state("send");
    endtask

    task automatic idle();
        con.valid_i = 1'b0;
        con.data_i  = 8'($urandom);
        exp_ce      = 1'b0;
        @(negedge clk);
        chk_state("idle");
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = int'($urandom_range(0, 7));
        if (r <= 3) return 8'(32'h20 + $urandom_range(0, 94));
        if (r == 4) return 8'h0D;
        if (r == 5) return 8'h0A;
        if (r == 6) return 8'h08;
`ifdef VGACHARGEN_CONSOLE_CLEAR_EN
        return $urandom_range(0, 1) == 1 ? 8'(32'h7F + $urandom_range(0, 128)) : 8'h1B;
`else
        return $urandom_range(0, 1) == 1 ? 8'(32'h7F + $urandom_range(0, 128)) : 8'h0C;
`endif
    endfunction

    initial begin
        con.valid_i = 1'b0;
        con.data_i  = 8'h00;
        exp_ce      = 1'b0;
        exp_be      = 4'h0;
        exp_addr    = 32'h0;
        exp_wd      = 32'h0;
        exp_ready   = 1'b1;
        exp_busy    = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset("reset");
        arstn = 1'b1;
        @(negedge clk);
        chk_state("post_reset");

        send(8'h41);
        chk("a.addr", 32'(con.char_map_addr_o), 32'h0);
        chk("a.be", 32'(con.char_map_be_o), 32'h1);
        chk("a.wdata", con.char_map_wdata_o, 32'h41414141);
        chk("a.col", 32'(con.col_o), 32'h1);

        send(8'h0D);
        send(8'h41);
        send(8'h42);
        send(8'h43);
        send(8'h44);
        chk("abcd.be", 32'(con.char_map_be_o), 32'h8);
        send(8'h45);
        chk("e.addr", 32'(con.char_map_addr_o), 32'h1);
        chk("e.be", 32'(con.char_map_be_o), 32'h1);
        idle();

        repeat (ROWS - 1) send(8'h0A);
        repeat (COLS - 1) send(8'(32'h20 + $urandom_range(0, 94)));
        chk("corner.col", 32'(con.col_o), 32'(COLS - 1));
        chk("corner.row", 32'(con.row_o), 32'(ROWS - 1));
        send(8'h5A);
        chk("wrap.addr", 32'(con.char_map_addr_o), 32'(NW - 1));
        chk("wrap.be", 32'(con.char_map_be_o), 32'h8);
        chk("wrap.col", 32'(con.col_o), 32'h0);
        chk("wrap.row", 32'(con.row_o), 32'h0);

        send(8'h41);
        send(8'h42);
        send(8'h08);
        send(8'h08);
        send(8'h08);
        chk("bs.col", 32'(con.col_o), 32'h0);
        send(8'h0A);
        chk("lf.row", 32'(con.row_o), 32'h1);
        idle();

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else send(rand_byte());
        end
        idle();

`ifdef VGACHARGEN_CONSOLE_CLEAR_EN
        con.valid_i = 1'b1;
        con.data_i  = 8'h0C;
        @(negedge clk);
        con.data_i = 8'h51;
        for (int i = 0; i < NW; i++) begin
            chk("clr.ce", 32'(con.char_map_ce_o), 32'h1);
            chk("clr.we", 32'(con.char_map_we_o), 32'h1);
            chk("clr.be", 32'(con.char_map_be_o), 32'hF);
            chk("clr.addr", 32'(con.char_map_addr_o), 32'(i));
            chk("clr.wdata", con.char_map_wdata_o, 32'h20202020);
            chk("clr.ready", 32'(con.ready_o), 32'h0);
            chk("clr.busy", 32'(con.busy_o), 32'h1);
            @(negedge clk);
        end
        cur       = 0;
        exp_ce    = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        chk_state("clr_done");
        model(8'h51);
        @(negedge clk);
        chk_state("clr_q");
        chk("q.addr", 32'(con.char_map_addr_o), 32'h0);
        chk("q.be", 32'(con.char_map_be_o), 32'h1);
        idle();

        send(8'h43);
        con.data_i = 8'h0C;
        @(negedge clk);
        con.valid_i = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid.addr", 32'(con.char_map_addr_o), 32'd100);
`else
        send(8'h0C);
        send(8'h43);
        send(8'h44);
`endif
        arstn = 1'b0;
        con.valid_i = 1'b1;
        #1;
        chk_reset("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset("abort_hold");
        end
        con.valid_i = 1'b0;
        arstn = 1'b1;
        cur   = 0;
        exp_ce    = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        @(negedge clk);
        chk_state("rearm");
        send(8'h52);
        chk("r.addr", 32'(con.char_map_addr_o), 32'h0);
        chk("r.be", 32'(con.char_map_be_o), 32'h1);
        chk("r.wdata", con.char_map_wdata_o, 32'h52525252);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
